// File: rtl/local_port_inj_arbiter.sv
// Round-robin arbiter sharing one router Local input port between NUM_REQ
// packet injectors. One flit is in flight at a time; the winner is told it
// was served only after the router has accepted its flit.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no flit in flight, arbitrate when a request is pending and
//          | the router Local FIFO has room
// WAIT_GNT | flit presented to the router, waiting for GntDnStr
// RELEASE  | one-cycle grant pulse back to the winner, requests ignored
module local_port_inj_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int dataWidth = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           ReqUp,
  input  logic [NUM_REQ*dataWidth-1:0] PacketUp,
  output logic [NUM_REQ-1:0]           GntUp,
  output logic                         ReqDnStr,
  input  logic                         GntDnStr,
  input  logic                         DnStrFull,
  output logic [dataWidth-1:0]         PacketOut,
  output logic [IDX_W-1:0]             GrantIdx,
  output logic [31:0]                  PktCount
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_GNT = 2'b01,
    RELEASE  = 2'b10
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;

  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [dataWidth-1:0] w_pkt_arr [NUM_REQ];

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_lane
      assign w_pkt_arr[g] = PacketUp[g*dataWidth +: dataWidth];
    end
  endgenerate

  // Round-robin pick: scan from the farthest candidate back to last+1 so the
  // nearest requester after the previous winner is the one left standing.
  // Sums wrap with a single subtract since last < NUM_REQ and k <= NUM_REQ.
  always_comb begin
    int s;
    s         = 0;
    w_found   = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      s = int'(r_last) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (ReqUp[IDX_W'(s)]) begin
        w_found   = 1'b1;
        w_win_idx = IDX_W'(s);
      end
    end
  end

  // Arbitration FSM with registered outputs; reset abandons any flit in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= IDX_W'(NUM_REQ - 1);
      GntUp     <= '0;
      ReqDnStr  <= 1'b0;
      PacketOut <= '0;
      GrantIdx  <= '0;
      PktCount  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          GntUp <= '0;
          if (w_found && !DnStrFull) begin
            PacketOut <= w_pkt_arr[w_win_idx];
            GrantIdx  <= w_win_idx;
            ReqDnStr  <= 1'b1;
            r_state   <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (GntDnStr) begin
            ReqDnStr <= 1'b0;
            GntUp    <= NUM_REQ'(1) << GrantIdx;
            r_last   <= GrantIdx;
            PktCount <= PktCount + 32'd1;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          GntUp   <= '0;
          r_state <= IDLE;
        end
        default: begin
          GntUp    <= '0;
          ReqDnStr <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_port_inj_arbiter.sv
// Directed bench for local_port_inj_arbiter: inputs driven on the falling
// edge, outputs sampled on the falling edge after each rising edge.
module tb_local_port_inj_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   ReqUp = '0;
  logic [127:0] PacketUp = '0;
  logic [3:0]   GntUp;
  logic         ReqDnStr;
  logic         GntDnStr = 1'b0;
  logic         DnStrFull = 1'b0;
  logic [31:0]  PacketOut;
  logic [1:0]   GrantIdx;
  logic [31:0]  PktCount;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [31:0] lane_val [4];

  local_port_inj_arbiter #(.NUM_REQ(4), .IDX_W(2), .dataWidth(32)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .ReqUp     (ReqUp),
    .PacketUp  (PacketUp),
    .GntUp     (GntUp),
    .ReqDnStr  (ReqDnStr),
    .GntDnStr  (GntDnStr),
    .DnStrFull (DnStrFull),
    .PacketOut (PacketOut),
    .GrantIdx  (GrantIdx),
    .PktCount  (PktCount)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One full packet: request, router grant, winner drops its request.
  task automatic run_pkt(input string tag, input logic [3:0] req, input int exp_idx);
    ReqUp = req;
    @(negedge clk);
    check_val({tag, " ReqDnStr"}, 32'(ReqDnStr), 32'd1);
    check_val({tag, " GrantIdx"}, 32'(GrantIdx), 32'(exp_idx));
    check_val({tag, " PacketOut"}, PacketOut, lane_val[exp_idx]);
    check_val({tag, " GntUp early"}, 32'(GntUp), 32'd0);
    GntDnStr = 1'b1;
    @(negedge clk);
    GntDnStr = 1'b0;
    exp_cnt++;
    check_val({tag, " GntUp"}, 32'(GntUp), 32'(4'(1) << exp_idx));
    check_val({tag, " ReqDnStr drop"}, 32'(ReqDnStr), 32'd0);
    check_val({tag, " PktCount"}, PktCount, 32'(exp_cnt));
    ReqUp[exp_idx] = 1'b0;
    @(negedge clk);
    check_val({tag, " GntUp release"}, 32'(GntUp), 32'd0);
  endtask

  initial begin
    lane_val[0] = 32'hA1B2C3D4;
    lane_val[1] = 32'h11110001;
    lane_val[2] = 32'h22220002;
    lane_val[3] = 32'h33330003;
    PacketUp = {lane_val[3], lane_val[2], lane_val[1], lane_val[0]};

    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst GntUp", 32'(GntUp), 32'd0);
    check_val("rst ReqDnStr", 32'(ReqDnStr), 32'd0);
    check_val("rst PacketOut", PacketOut, 32'd0);
    check_val("rst GrantIdx", 32'(GrantIdx), 32'd0);
    check_val("rst PktCount", PktCount, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single requester, router grants two cycles after the request.
    ReqUp = 4'b0001;
    @(negedge clk);
    check_val("single ReqDnStr", 32'(ReqDnStr), 32'd1);
    check_val("single PacketOut", PacketOut, 32'hA1B2C3D4);
    @(negedge clk);
    check_val("single hold", 32'(ReqDnStr), 32'd1);
    GntDnStr = 1'b1;
    @(negedge clk);
    GntDnStr = 1'b0;
    check_val("single GntUp", 32'(GntUp), 32'd1);
    check_val("single PktCount", PktCount, 32'd1);
    ReqUp = 4'b0000;
    @(negedge clk);
    check_val("single GntUp pulse", 32'(GntUp), 32'd0);

    // Reset in the middle of WAIT_GNT takes effect before the next clock edge.
    ReqUp = 4'b0100;
    @(negedge clk);
    check_val("midrst ReqDnStr pre", 32'(ReqDnStr), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_val("midrst ReqDnStr", 32'(ReqDnStr), 32'd0);
    check_val("midrst PacketOut", PacketOut, 32'd0);
    check_val("midrst GrantIdx", 32'(GrantIdx), 32'd0);
    check_val("midrst PktCount", PktCount, 32'd0);
    check_val("midrst GntUp", 32'(GntUp), 32'd0);
    ReqUp = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst idle", 32'(ReqDnStr), 32'd0);
    exp_cnt = 0;

    // Round robin with every requester active; order 0,1,2,3,0.
    run_pkt("rr0", 4'b1111, 0);
    run_pkt("rr1", 4'b1111, 1);
    run_pkt("rr2", 4'b1111, 2);
    run_pkt("rr3", 4'b1111, 3);
    run_pkt("rr4", 4'b1111, 0);
    check_val("rr PktCount", PktCount, 32'd5);

    // Skip: after winner 1, requests 0 and 3 -> 3 first, then 0.
    run_pkt("skip1", 4'b0010, 1);
    run_pkt("skip3", 4'b1001, 3);
    run_pkt("skip0", 4'b0001, 0);

    // Full router FIFO blocks arbitration.
    DnStrFull = 1'b1;
    ReqUp = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("full blocked", 32'(ReqDnStr), 32'd0);
    end
    DnStrFull = 1'b0;
    run_pkt("full release", 4'b0100, 2);

    // Stray router grant in IDLE.
    ReqUp = 4'b0000;
    GntDnStr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("stray idle GntUp", 32'(GntUp), 32'd0);
    check_val("stray idle PktCount", PktCount, 32'(exp_cnt));
    GntDnStr = 1'b0;

    // Router grant held high through RELEASE and back into IDLE.
    ReqUp = 4'b0001;
    @(negedge clk);
    GntDnStr = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check_val("stray grant", 32'(GntUp), 32'd1);
    ReqUp = 4'b0000;
    @(negedge clk);
    check_val("stray rel GntUp", 32'(GntUp), 32'd0);
    check_val("stray rel PktCount", PktCount, 32'(exp_cnt));
    @(negedge clk);
    check_val("stray post GntUp", 32'(GntUp), 32'd0);
    check_val("stray post ReqDnStr", 32'(ReqDnStr), 32'd0);
    check_val("stray post PktCount", PktCount, 32'(exp_cnt));
    GntDnStr = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
